vic20_prg_loader: RTL and testbench
===================================

# vic20_prg_loader

Downstream stage of the SPI data_io file-download stream and upstream of the SDRAM/internal-memory write port. Turns a PRG or CRT download into addressed byte writes, honouring the 2-byte load-address header or forcing raw loads to $A000. After the download it injects the BASIC end pointers into zero page. It then issues a one-cycle reset request if a cartridge image was loaded.

## Interface
Parameters:
- CART_BASE, 16'hA000, raw-load base and auto-reset trigger address.

Ports:
- clk_sys  in  1  system clock (32 MHz domain)
- reset_n  in  1  asynchronous, active-low reset
- dl_active  in  1  PRG/CRT download in progress (index ≠ 0)
- dl_wr  in  1  one-cycle byte strobe from data_io
- dl_addr  in  16  byte offset within file
- dl_data  in  8  file byte
- hdr_mode  in  1  1 = bytes 0/1 are load address (LSB first); 0 = raw, load at CART_BASE
- mem_wr  out  1  one-cycle write strobe
- mem_addr  out  16  write address
- mem_data  out  8  write data
- mem_internal  out  1  mem_addr decodes to internal RAM: $0000-$03FF, $1000-$1FFF, $9400-$97FF
- force_reset  out  1  one-cycle machine-reset request
- busy  out  1  download or injection in progress

## Operation
- States: IDLE, LOAD, INJECT, FINISH.
- IDLE → LOAD on dl_active=1. LOAD → INJECT on dl_active falling. INJECT → FINISH at inject count 15. FINISH → IDLE at count 31.
- LOAD, hdr_mode=1:
  - offset 0 latches load_addr[7:0]; offset 1 latches load_addr[15:8]; neither produces mem_wr.
  - offset n≥2 writes dl_data to load_addr+(n-2).
- LOAD, hdr_mode=0: offset n writes to CART_BASE+n.
- hdr_mode is sampled at offset 0 and held for the rest of the file.
- Write pointer wp = address of the next byte. end_ptr = last written address + 1.
  - With no data bytes, end_ptr = load_addr (header mode) or CART_BASE (raw).
- Address arithmetic is 16-bit modulo; $FFFF+1 = $0000.
- cart_flag: set on any data write to CART_BASE during LOAD; cleared on entry to LOAD and after FINISH.
- INJECT writes 8 bytes, in this order:
  - end_ptr[7:0] → $2D, end_ptr[15:8] → $2E
  - end_ptr[7:0] → $2F, end_ptr[15:8] → $30
  - end_ptr[7:0] → $31, end_ptr[15:8] → $32
  - end_ptr[7:0] → $AE, end_ptr[15:8] → $AF
- FINISH: at count 31, force_reset = cart_flag for one cycle; cart_flag clears.
- dl_wr is ignored outside LOAD. dl_active=0 with dl_wr=1 in the same cycle: the byte is dropped.
- dl_active rising during INJECT/FINISH: abort, no force_reset, enter LOAD, cart_flag cleared.
- reset_n low at any time: all outputs 0, state IDLE, load_addr/wp/end_ptr/cart_flag = 0, immediately (async).
- mem_internal is combinational on mem_addr and is qualified by mem_wr at the consumer.

## Timing
- All outputs except mem_internal are registered.
- Reset values: mem_wr=0, mem_addr=0, mem_data=0, force_reset=0, busy=0.
- Load latency: dl_wr at edge k → mem_wr, mem_addr, mem_data valid for exactly cycle k+1.
- Back-to-back dl_wr is supported, one write per cycle.
- Injection counter c starts at 1 on the edge after dl_active falls, then increments every cycle.
- Injected writes occur in cycles c ∈ {1,3,5,...,15}, giving 2-cycle spacing.
- force_reset fires in cycle c=31.
- busy is high from the first LOAD cycle through c=31 inclusive.

## Structure
- Package vic20_loader_pkg:
  - state enum
  - CART_BASE default
  - 8-entry pointer address list ($2D..$32, $AE, $AF)
  - internal-region decode constants
- One sub-module is natural: vic20_mem_region, the combinational mem_internal decoder, reusable by the ROM download path.

## Test plan
- Header PRG: bytes 01 10 AA BB CC → writes $1001=AA, $1002=BB, $1003=CC. Then injection writes $2D=04, $2E=10, ... $AF=10. No force_reset.
- Raw CRT, hdr_mode=0, 4 bytes → writes $A000-$A003, mem_internal=0. Injection end_ptr=$A004; force_reset pulses exactly at c=31.
- Header load at $FFFE with 3 data bytes → writes $FFFE, $FFFF, $0000 (wrap). end_ptr=$0001.
- dl_active re-asserted at c=9 → remaining injections suppressed, no force_reset, busy stays high, new load proceeds.
- reset_n low mid-LOAD and mid-INJECT → all outputs 0 that cycle. No further writes until the next dl_active.
- Decoder sweep: $03FF/$1000/$97FF → mem_internal=1; $0400/$2000/$9800 → 0.

Source files
------------

// File: rtl/vic20_loader_pkg.sv
// Shared types and constants for the VIC-20 PRG/CRT download loader:
// FSM states, cartridge base, BASIC pointer addresses and internal-RAM map.
package vic20_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_INJECT = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam logic [15:0] CART_BASE_DEFAULT = 16'hA000;

  localparam logic [4:0] INJECT_LAST = 5'd15;
  localparam logic [4:0] FINISH_LAST = 5'd31;

  localparam logic [15:0] RAM_LO_START  = 16'h0000;
  localparam logic [15:0] RAM_LO_END    = 16'h03FF;
  localparam logic [15:0] RAM_BLK_START = 16'h1000;
  localparam logic [15:0] RAM_BLK_END   = 16'h1FFF;
  localparam logic [15:0] COLOR_START   = 16'h9400;
  localparam logic [15:0] COLOR_END     = 16'h97FF;

  // BASIC start-of-variables/arrays/end-of-arrays and KERNAL load-end pointers.
  function automatic logic [15:0] ptr_addr(input logic [2:0] idx);
    logic [15:0] a;
    case (idx)
      3'd0:    a = 16'h002D;
      3'd1:    a = 16'h002E;
      3'd2:    a = 16'h002F;
      3'd3:    a = 16'h0030;
      3'd4:    a = 16'h0031;
      3'd5:    a = 16'h0032;
      3'd6:    a = 16'h00AE;
      3'd7:    a = 16'h00AF;
      default: a = 16'h0000;
    endcase
    return a;
  endfunction

  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/vic20_mem_region.sv
// Combinational decoder: flags addresses that land in VIC-20 internal RAM
// (low 1K, the 4K main block and colour RAM).
module vic20_mem_region
  import vic20_loader_pkg::*;
(
  input  logic [15:0] addr_i,
  output logic        internal_o
);

  always_comb begin
    internal_o = in_range(addr_i, RAM_LO_START,  RAM_LO_END)  ||
                 in_range(addr_i, RAM_BLK_START, RAM_BLK_END) ||
                 in_range(addr_i, COLOR_START,   COLOR_END);
  end

endmodule

// File: rtl/vic20_prg_loader.sv
// Converts a PRG/CRT download stream into addressed memory writes, then
// patches the BASIC end pointers and optionally requests a machine reset.
module vic20_prg_loader
  import vic20_loader_pkg::*;
#(
  parameter logic [15:0] CART_BASE = CART_BASE_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        hdr_mode,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_internal,
  output logic        force_reset,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] load_addr_q, load_addr_d;
  logic [15:0] wp_q, wp_d;
  logic [15:0] end_ptr_q, end_ptr_d;
  logic        cart_flag_q, cart_flag_d;
  logic        hdr_q, hdr_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic        force_reset_q, force_reset_d;
  logic        busy_q, busy_d;

  logic        enter_load_s;
  logic        inj_emit_s;
  logic [2:0]  inj_idx_s;
  logic [15:0] inj_ptr_s;
  logic        use_hdr_s;
  logic [15:0] data_addr_s;
  logic [4:0]  cnt_inc_s;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load_addr_d   = load_addr_q;
    wp_d          = wp_q;
    end_ptr_d     = end_ptr_q;
    cart_flag_d   = cart_flag_q;
    hdr_d         = hdr_q;
    mem_wr_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    force_reset_d = 1'b0;
    enter_load_s  = 1'b0;
    inj_emit_s    = 1'b0;
    inj_idx_s     = 3'd0;
    inj_ptr_s     = end_ptr_q;
    cnt_inc_s     = cnt_q + 5'd1;
    // hdr_mode is only honoured on the first byte; later bytes use the latched copy
    use_hdr_s     = (dl_addr == 16'h0000) ? hdr_mode : hdr_q;
    data_addr_s   = use_hdr_s ? (load_addr_q + dl_addr - 16'd2) : (CART_BASE + dl_addr);

    case (state_q)
      ST_IDLE: begin
        if (dl_active) begin
          state_d      = ST_LOAD;
          enter_load_s = 1'b1;
        end else begin
          cnt_d = 5'd0;
        end
      end

      ST_LOAD: begin
        if (!dl_active) begin
          // first pointer byte goes out together with c=1, straight from wp
          state_d    = ST_INJECT;
          cnt_d      = 5'd1;
          end_ptr_d  = wp_q;
          inj_ptr_s  = wp_q;
          inj_emit_s = 1'b1;
          inj_idx_s  = 3'd0;
        end else if (dl_wr) begin
          if (dl_addr == 16'h0000) begin
            hdr_d = hdr_mode;
          end else begin
            hdr_d = hdr_q;
          end
          if (use_hdr_s && (dl_addr == 16'h0000)) begin
            load_addr_d[7:0] = dl_data;
          end else if (use_hdr_s && (dl_addr == 16'h0001)) begin
            load_addr_d[15:8] = dl_data;
            wp_d              = {dl_data, load_addr_q[7:0]};
          end else begin
            mem_wr_d   = 1'b1;
            mem_addr_d = data_addr_s;
            mem_data_d = dl_data;
            wp_d       = data_addr_s + 16'd1;
            if (data_addr_s == CART_BASE) begin
              cart_flag_d = 1'b1;
            end else begin
              cart_flag_d = cart_flag_q;
            end
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_INJECT, ST_FINISH: begin
        if (dl_active) begin
          state_d      = ST_LOAD;
          enter_load_s = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s[0] && (cnt_inc_s <= INJECT_LAST)) begin
            inj_emit_s = 1'b1;
            inj_idx_s  = cnt_inc_s[3:1];
          end else begin
            inj_emit_s = 1'b0;
          end
          if ((state_q == ST_INJECT) && (cnt_q == INJECT_LAST)) begin
            state_d = ST_FINISH;
          end else if ((state_q == ST_FINISH) && (cnt_inc_s == FINISH_LAST)) begin
            force_reset_d = cart_flag_q;
          end else if ((state_q == ST_FINISH) && (cnt_q == FINISH_LAST)) begin
            state_d     = ST_IDLE;
            cnt_d       = 5'd0;
            cart_flag_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 5'd0;
      end
    endcase

    if (enter_load_s) begin
      cnt_d       = 5'd0;
      cart_flag_d = 1'b0;
      wp_d        = CART_BASE;
    end else begin
      cnt_d = cnt_d;
    end

    if (inj_emit_s) begin
      mem_wr_d   = 1'b1;
      mem_addr_d = ptr_addr(inj_idx_s);
      mem_data_d = inj_idx_s[0] ? inj_ptr_s[15:8] : inj_ptr_s[7:0];
    end else begin
      mem_data_d = mem_data_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 5'd0;
      load_addr_q   <= 16'h0000;
      wp_q          <= 16'h0000;
      end_ptr_q     <= 16'h0000;
      cart_flag_q   <= 1'b0;
      hdr_q         <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= 16'h0000;
      mem_data_q    <= 8'h00;
      force_reset_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      load_addr_q   <= load_addr_d;
      wp_q          <= wp_d;
      end_ptr_q     <= end_ptr_d;
      cart_flag_q   <= cart_flag_d;
      hdr_q         <= hdr_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      force_reset_q <= force_reset_d;
      busy_q        <= busy_d;
    end
  end

  vic20_mem_region u_region (
    .addr_i     (mem_addr_q),
    .internal_o (mem_internal)
  );

  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign force_reset = force_reset_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vic20_prg_loader.sv
// Directed self-checking bench for vic20_prg_loader: header/raw loads, wrap,
// pointer injection, cartridge reset, abort, async reset and region decode.
module tb_vic20_prg_loader;

  logic        clk_sys;
  logic        reset_n;
  logic        dl_active;
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        hdr_mode;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_internal;
  logic        force_reset;
  logic        busy;

  logic [15:0] dec_addr;
  logic        dec_int;

  int checks;
  int errors;

  vic20_prg_loader #(.CART_BASE(16'hA000)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .dl_active    (dl_active),
    .dl_wr        (dl_wr),
    .dl_addr      (dl_addr),
    .dl_data      (dl_data),
    .hdr_mode     (hdr_mode),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_internal (mem_internal),
    .force_reset  (force_reset),
    .busy         (busy)
  );

  vic20_mem_region u_dec (
    .addr_i     (dec_addr),
    .internal_o (dec_int)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] exp_ptr(input int i);
    logic [15:0] tbl [8];
    tbl = '{16'h002D, 16'h002E, 16'h002F, 16'h0030,
            16'h0031, 16'h0032, 16'h00AE, 16'h00AF};
    return tbl[i];
  endfunction

  task automatic start_load(input logic hdr);
    hdr_mode  = hdr;
    dl_active = 1'b1;
    @(posedge clk_sys); #1;
    checks++;
    if (busy !== 1'b1 || mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL start_load: busy=%b mem_wr=%b, need busy=1 mem_wr=0", busy, mem_wr);
    end
  endtask

  task automatic send(input logic [15:0] off, input logic [7:0] d, input logic exp_wr,
                      input logic [15:0] exp_addr, input logic exp_int);
    dl_wr   = 1'b1;
    dl_addr = off;
    dl_data = d;
    @(posedge clk_sys); #1;
    dl_wr = 1'b0;
    checks++;
    if (mem_wr !== exp_wr) begin
      errors++;
      $display("FAIL send_wr off=%h: mem_wr=%b need %b", off, mem_wr, exp_wr);
    end
    if (exp_wr) begin
      checks++;
      if (mem_addr !== exp_addr || mem_data !== d || mem_internal !== exp_int) begin
        errors++;
        $display("FAIL send_data off=%h: addr=%h data=%h int=%b need addr=%h data=%h int=%b",
                 off, mem_addr, mem_data, mem_internal, exp_addr, d, exp_int);
      end
    end
  endtask

  // Drops dl_active (with a stray byte that must be discarded) and checks c=1..31.
  task automatic run_inject(input logic [15:0] ep, input logic cart, input int abort_at);
    logic aborted;
    logic ew;
    logic [7:0] ed;
    aborted   = 1'b0;
    dl_active = 1'b0;
    dl_wr     = 1'b1;
    dl_addr   = 16'h0040;
    dl_data   = 8'hEE;
    for (int c = 1; c <= 31; c++) begin
      @(posedge clk_sys); #1;
      dl_wr = 1'b0;
      ew = (c % 2 == 1) && (c <= 15) && !aborted;
      ed = (((c - 1) / 2) % 2 == 1) ? ep[15:8] : ep[7:0];
      checks++;
      if (mem_wr !== ew) begin
        errors++;
        $display("FAIL inject_wr c=%0d: mem_wr=%b need %b", c, mem_wr, ew);
      end else if (ew && (mem_addr !== exp_ptr((c - 1) / 2) || mem_data !== ed)) begin
        errors++;
        $display("FAIL inject_data c=%0d: addr=%h data=%h need addr=%h data=%h",
                 c, mem_addr, mem_data, exp_ptr((c - 1) / 2), ed);
      end
      checks++;
      if (force_reset !== (cart && c == 31 && !aborted) || busy !== 1'b1) begin
        errors++;
        $display("FAIL inject_ctl c=%0d: force_reset=%b busy=%b need force_reset=%b busy=1",
                 c, force_reset, busy, (cart && c == 31 && !aborted));
      end
      if (c == abort_at) begin
        dl_active = 1'b1;
        aborted   = 1'b1;
      end
    end
    if (!aborted) begin
      @(posedge clk_sys); #1;
      checks++;
      if (busy !== 1'b0 || force_reset !== 1'b0 || mem_wr !== 1'b0) begin
        errors++;
        $display("FAIL inject_end: busy=%b force_reset=%b mem_wr=%b need all 0",
                 busy, force_reset, mem_wr);
      end
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (mem_wr !== 1'b0 || mem_addr !== 16'h0000 || mem_data !== 8'h00 ||
        force_reset !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: wr=%b addr=%h data=%h fr=%b busy=%b need all 0",
               name, mem_wr, mem_addr, mem_data, force_reset, busy);
    end
  endtask

  task automatic quiet_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      dl_wr   = 1'b1;
      dl_addr = 16'(i);
      dl_data = 8'h99;
      @(posedge clk_sys); #1;
      checks++;
      if (mem_wr !== 1'b0 || busy !== 1'b0 || force_reset !== 1'b0) begin
        errors++;
        $display("FAIL %s: wr=%b busy=%b fr=%b need 0", name, mem_wr, busy, force_reset);
      end
    end
    dl_wr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    check_zero("reset_state");
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    quiet_cycles("idle_ignores_wr", 3);
  endtask

  task automatic test_header_prg();
    start_load(1'b1);
    send(16'd0, 8'h01, 1'b0, 16'h0000, 1'b0);
    hdr_mode = 1'b0;
    send(16'd1, 8'h10, 1'b0, 16'h0000, 1'b0);
    send(16'd2, 8'hAA, 1'b1, 16'h1001, 1'b1);
    send(16'd3, 8'hBB, 1'b1, 16'h1002, 1'b1);
    send(16'd4, 8'hCC, 1'b1, 16'h1003, 1'b1);
    run_inject(16'h1004, 1'b0, 0);
  endtask

  task automatic test_raw_crt();
    start_load(1'b0);
    send(16'd0, 8'h09, 1'b1, 16'hA000, 1'b0);
    hdr_mode = 1'b1;
    send(16'd1, 8'hA0, 1'b1, 16'hA001, 1'b0);
    send(16'd2, 8'h0D, 1'b1, 16'hA002, 1'b0);
    send(16'd3, 8'h41, 1'b1, 16'hA003, 1'b0);
    run_inject(16'hA004, 1'b1, 0);
  endtask

  task automatic test_wrap();
    start_load(1'b1);
    send(16'd0, 8'hFE, 1'b0, 16'h0000, 1'b0);
    send(16'd1, 8'hFF, 1'b0, 16'h0000, 1'b0);
    send(16'd2, 8'h11, 1'b1, 16'hFFFE, 1'b0);
    send(16'd3, 8'h22, 1'b1, 16'hFFFF, 1'b0);
    send(16'd4, 8'h33, 1'b1, 16'h0000, 1'b1);
    run_inject(16'h0001, 1'b0, 0);
  endtask

  task automatic test_abort();
    start_load(1'b1);
    send(16'd0, 8'h00, 1'b0, 16'h0000, 1'b0);
    send(16'd1, 8'hA0, 1'b0, 16'h0000, 1'b0);
    send(16'd2, 8'h5A, 1'b1, 16'hA000, 1'b0);
    run_inject(16'hA001, 1'b1, 9);
    send(16'd0, 8'h00, 1'b0, 16'h0000, 1'b0);
    send(16'd1, 8'h20, 1'b0, 16'h0000, 1'b0);
    send(16'd2, 8'h77, 1'b1, 16'h2000, 1'b0);
    run_inject(16'h2001, 1'b0, 0);
  endtask

  task automatic test_reset_mid_load();
    start_load(1'b0);
    send(16'd0, 8'h77, 1'b1, 16'hA000, 1'b0);
    #2;
    reset_n   = 1'b0;
    dl_active = 1'b0;
    #1;
    check_zero("reset_mid_load");
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    quiet_cycles("after_reset_load", 4);
  endtask

  task automatic test_reset_mid_inject();
    start_load(1'b1);
    send(16'd0, 8'h00, 1'b0, 16'h0000, 1'b0);
    send(16'd1, 8'hA0, 1'b0, 16'h0000, 1'b0);
    send(16'd2, 8'h42, 1'b1, 16'hA000, 1'b0);
    dl_active = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if (mem_wr !== 1'b1 || mem_addr !== 16'h002E || mem_data !== 8'hA0) begin
      errors++;
      $display("FAIL pre_reset_inject: wr=%b addr=%h data=%h need 1 002e a0",
               mem_wr, mem_addr, mem_data);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("reset_mid_inject");
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    quiet_cycles("after_reset_inject", 35);
  endtask

  task automatic test_decoder();
    logic [15:0] addrs [6];
    logic        exps  [6];
    addrs = '{16'h03FF, 16'h1000, 16'h97FF, 16'h0400, 16'h2000, 16'h9800};
    exps  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      dec_addr = addrs[i];
      #1;
      checks++;
      if (dec_int !== exps[i]) begin
        errors++;
        $display("FAIL decode %h: internal=%b need %b", addrs[i], dec_int, exps[i]);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = 16'h0000;
    dl_data   = 8'h00;
    hdr_mode  = 1'b0;
    dec_addr  = 16'h0000;
    test_reset();
    test_header_prg();
    test_raw_crt();
    test_wrap();
    test_abort();
    test_reset_mid_load();
    test_reset_mid_inject();
    test_decoder();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
